// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Owner of the HI/LO register pair. Sequences multi-cycle multiply and
//   restoring divide, executes MTHI/MTLO, drives the writeback select for
//   MFHI/MFLO and stalls decode while an operation is in flight.
module hilo_muldiv_ctrl #(
  parameter int         MUL_LATENCY = 2,
  parameter logic [2:0] SEL_ALU     = 3'd0,
  parameter logic [2:0] SEL_HI      = 3'd3,
  parameter logic [2:0] SEL_LO      = 3'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        stall,
  output logic [2:0]  wb_sel,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        done
);

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_FIX  = 2'd3
  } state_e;

  // Architectural and sequencing state (q = registered, d = next value).
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;

  // Multiplier operand latches.
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               mul_signed_q, mul_signed_d;

  // Divider working registers: partial remainder, dividend/quotient shift
  // register (dividend bits leave at the top, quotient bits enter at the
  // bottom), divisor magnitude and the result sign fixups.
  logic [31:0]        div_rem_q, div_rem_d;
  logic [31:0]        div_quo_q, div_quo_d;
  logic [31:0]        div_dsr_q, div_dsr_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;

  op_e                op;
  logic               accept;
  logic               is_signed;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [63:0]        prod_u;
  logic [63:0]        prod_s;
  logic [32:0]        div_shifted;
  logic [32:0]        div_diff;
  logic               div_ge;
  logic [31:0]        div_rem_step;
  logic [31:0]        div_quo_step;

  assign op       = op_e'(op_code);
  assign op_ready = (state_q == IDLE);
  assign accept   = op_valid & op_ready;
  assign stall    = op_valid & ~op_ready;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign done     = done_q;

  // Only MULT and DIV treat operands as two's complement.
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  // Operand magnitudes for signed divide; -2^31 maps to 32'h80000000,
  // which is its correct magnitude when read as unsigned.
  assign abs_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign abs_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // Low 64 bits of a product of sign-extended operands equal the signed
  // product, so both flavours use a plain unsigned multiplier.
  assign prod_u = {32'd0, mul_a_q} * {32'd0, mul_b_q};
  assign prod_s = {{32{mul_a_q[31]}}, mul_a_q} * {{32{mul_b_q[31]}}, mul_b_q};

  // One restoring-division step: shift in the next dividend bit, try to
  // subtract the divisor, keep the difference if it did not go negative.
  assign div_shifted  = {div_rem_q, div_quo_q[31]};
  assign div_diff     = div_shifted - {1'b0, div_dsr_q};
  assign div_ge       = ~div_diff[32];
  assign div_rem_step = div_ge ? div_diff[31:0] : div_shifted[31:0];
  assign div_quo_step = {div_quo_q[30:0], div_ge};

  // Writeback select: only an MFHI/MFLO accepted this cycle steers the mux.
  always_comb begin
    wb_sel = SEL_ALU;
    if (accept && op == OP_MFHI) wb_sel = SEL_HI;
    if (accept && op == OP_MFLO) wb_sel = SEL_LO;
  end

  // Next-state and datapath update logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    div_rem_d    = div_rem_q;
    div_quo_d    = div_quo_q;
    div_dsr_d    = div_dsr_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d      = op_a;
              mul_b_d      = op_b;
              mul_signed_d = is_signed;
              cnt_d        = CNT_W'(MUL_LATENCY - 1);
              state_d      = MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              if (op_b == 32'd0) begin
                // Divide by zero completes immediately with a fixed result.
                hi_d   = op_a;
                lo_d   = 32'hFFFF_FFFF;
                done_d = 1'b1;
              end else begin
                div_rem_d = 32'd0;
                div_quo_d = abs_a;
                div_dsr_d = abs_b;
                q_neg_d   = is_signed & (op_a[31] ^ op_b[31]);
                r_neg_d   = is_signed & op_a[31];
                cnt_d     = CNT_W'(31);
                state_d   = DIV_RUN;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;  // MFHI/MFLO only affect wb_sel
          endcase
        end
      end

      MUL_WAIT: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_signed_q ? prod_s : prod_u;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DIV_RUN: begin
        div_rem_d = div_rem_step;
        div_quo_d = div_quo_step;
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DIV_FIX: begin
        lo_d    = q_neg_q ? (~div_quo_q + 32'd1) : div_quo_q;
        hi_d    = r_neg_q ? (~div_rem_q + 32'd1) : div_rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: the datapath latches are cleared on reset as well as the
      // architectural state, so an aborted op leaves nothing behind.
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      done_q       <= 1'b0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      mul_signed_q <= 1'b0;
      div_rem_q    <= 32'd0;
      div_quo_q    <= 32'd0;
      div_dsr_q    <= 32'd0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      done_q       <= done_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      div_rem_q    <= div_rem_d;
      div_quo_q    <= div_quo_d;
      div_dsr_q    <= div_dsr_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
    end
  end

endmodule
